// File: rtl/scope_trigger_capture_pkg.sv
// Shared types and helpers for the triggered dual-channel scope capture block.
// Holds the FSM state encoding, default widths and the hysteresis band helpers.
package scope_trigger_capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StPost,
    StDone
  } state_e;

  localparam int unsigned DefDataW  = 14;
  localparam int unsigned DefAddrW  = 10;
  localparam int unsigned DefDecimW = 8;

  // Offset-binary zero point of the ADC.
  localparam logic [DefDataW-1:0] Midscale = 14'h2000;

  // Band edges are computed at 32 bits so neither end can wrap before clamping.
  function automatic int unsigned band_lo(input int unsigned level, input int unsigned hyst);
    return (level > hyst) ? (level - hyst) : 32'd0;
  endfunction

  function automatic int unsigned band_hi(input int unsigned level, input int unsigned hyst,
                                          input int unsigned max_code);
    return ((level + hyst) > max_code) ? max_code : (level + hyst);
  endfunction

endpackage

// File: rtl/scope_trigger_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module scope_trigger_capture_ram #(
  parameter int unsigned WIDTH  = 28,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [Depth];

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Captures one triggered dual-channel ADC record into a circular buffer with
// decimation, programmable pre-trigger depth, hysteresis trigger and auto-trigger.
module scope_trigger_capture
  import scope_trigger_capture_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DECIM_W  = DefDecimW,
  parameter int unsigned AUTO_CYC = 65535
) (
  input  logic               clk_adc,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  adc_a,
  input  logic [DATA_W-1:0]  adc_b,
  input  logic               arm,
  input  logic               trig_src,
  input  logic               trig_edge,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DATA_W-1:0]  trig_hyst,
  input  logic               trig_auto,
  input  logic [ADDR_W-1:0]  pre_count,
  input  logic [DECIM_W-1:0] decim,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  output logic               busy,
  output logic               done,
  output logic               auto_fired,
  output logic [ADDR_W-1:0]  start_addr
);

  localparam int unsigned AutoW   = $clog2(AUTO_CYC + 1);
  localparam int unsigned MaxCode = (32'd1 << DATA_W) - 32'd1;
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_CYC - 1);

  state_e             state_q;
  logic               src_q, edge_q, auto_q, rearm_q;
  logic [DATA_W-1:0]  level_q, lo_q, hi_q;
  logic [ADDR_W-1:0]  pre_q, wr_ptr_q, pre_cnt_q, post_cnt_q;
  logic [DECIM_W-1:0] decim_q, dec_cnt_q;
  logic [AutoW-1:0]   wait_cnt_q;

  logic               stb, capturing, we;
  logic               rearm_hit, level_hit, real_trig, auto_trig;
  logic [DATA_W-1:0]  x;
  logic [ADDR_W-1:0]  post_len;
  logic [2*DATA_W-1:0] rdata;

  always_comb begin
    stb       = (dec_cnt_q == decim_q);
    capturing = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    // The arm cycle itself never stores: the capture restarts cleanly on the next strobe.
    we        = stb && capturing && !arm;
    x         = src_q ? adc_b : adc_a;
    rearm_hit = edge_q ? (x <= lo_q) : (x >= hi_q);
    level_hit = edge_q ? (x >= level_q) : (x <= level_q);
    real_trig = rearm_q && level_hit;
    auto_trig = auto_q && (wait_cnt_q == AutoLast);
    // DEPTH - pre - 1; pre_count cannot exceed DEPTH-1 at ADDR_W bits, so no clamp needed.
    post_len  = ~pre_q;
  end

  scope_trigger_capture_ram #(
    .WIDTH  (2 * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_adc),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({adc_b, adc_a}),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  assign rd_data_a = rdata[DATA_W-1:0];
  assign rd_data_b = rdata[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= 1'b0;
      edge_q     <= 1'b0;
      auto_q     <= 1'b0;
      rearm_q    <= 1'b0;
      level_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      pre_q      <= '0;
      decim_q    <= '0;
      dec_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      wait_cnt_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      auto_fired <= 1'b0;
      start_addr <= '0;
    end else begin
      if (arm || stb) begin
        dec_cnt_q <= '0;
      end else begin
        dec_cnt_q <= dec_cnt_q + DECIM_W'(1);
      end

      if (we) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end

      if (arm) begin
        src_q      <= trig_src;
        edge_q     <= trig_edge;
        auto_q     <= trig_auto;
        level_q    <= trig_level;
        lo_q       <= DATA_W'(band_lo(32'(trig_level), 32'(trig_hyst)));
        hi_q       <= DATA_W'(band_hi(32'(trig_level), 32'(trig_hyst), MaxCode));
        pre_q      <= pre_count;
        decim_q    <= decim;
        rearm_q    <= 1'b0;
        pre_cnt_q  <= '0;
        post_cnt_q <= '0;
        wait_cnt_q <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
        auto_fired <= 1'b0;
        state_q    <= (pre_count == '0) ? StWait : StPre;
      end else if (stb) begin
        unique case (state_q)
          StPre: begin
            rearm_q   <= rearm_q | rearm_hit;
            pre_cnt_q <= pre_cnt_q + ADDR_W'(1);
            if (pre_cnt_q == pre_q - ADDR_W'(1)) begin
              state_q <= StWait;
            end
          end
          StWait: begin
            rearm_q    <= rearm_q | rearm_hit;
            wait_cnt_q <= wait_cnt_q + AutoW'(1);
            if (real_trig || auto_trig) begin
              // The trigger sample lands at wr_ptr_q this cycle.
              start_addr <= wr_ptr_q - pre_q;
              auto_fired <= !real_trig;
              if (post_len == '0) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_q <= StPost;
              end
            end
          end
          StPost: begin
            post_cnt_q <= post_cnt_q + ADDR_W'(1);
            if (post_cnt_q == post_len - ADDR_W'(1)) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
